// File: rtl/nfc_seq_pkg.sv
// Shared definitions for the NFC host command sequencer: command encodings,
// completion codes and the sequencer state encoding.
package nfc_seq_pkg;

    localparam logic [2:0] CMD_PRG   = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_ERASE = 3'b100;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_NFCERR  = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILL,
        ST_START,
        ST_WAIT,
        ST_DRAIN,
        ST_RESP
    } seq_state_t;

endpackage

// File: rtl/nfc_seq_rdbuf.sv
// Read-drain output stage: one-entry output register plus an outstanding-read
// flag, so at most one buffer read is in flight and no word is dropped while
// the host stalls rd_ready.
module nfc_seq_rdbuf
    import nfc_seq_pkg::*;
#(
    parameter int DIOWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                more,
    input  logic [DIOWidth-1:0] buf_out,
    input  logic                rd_ready,
    output logic                buf_re,
    output logic                rd_valid,
    output logic [DIOWidth-1:0] rd_data,
    output logic                pop,
    output logic                pend
);

    logic                pend_q, pend_d;
    logic                vld_q, vld_d;
    logic [DIOWidth-1:0] data_q, data_d;

    // Issue a read only when nothing is in flight and the register will be free
    always_comb begin
        buf_re = en && more && !pend_q && (!vld_q || rd_ready);
        pop    = vld_q && rd_ready;
        pend_d = buf_re;
        vld_d  = vld_q;
        data_d = data_q;
        if (pend_q) begin
            // buf_out is valid the cycle after the strobe
            vld_d  = 1'b1;
            data_d = buf_out;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    // Output register and in-flight flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign rd_valid = vld_q;
    assign rd_data  = data_q;
    assign pend     = pend_q;

endmodule

// File: rtl/nfc_host_seq.sv
// Host-side command sequencer in front of the NAND flash controller host port.
// Takes one program/read/erase request at a time, fills or drains the NFC page
// buffer and reports a completion code.
// Build option: define NFC_TIMEOUT_EN to add a watchdog on the wait for
// nfc_done (completion code 11 after TimeoutCycles cycles).
module nfc_host_seq
    import nfc_seq_pkg::*;
#(
    parameter int DIOWidth      = 16,
    parameter int AddressWidth  = 16,
    parameter int CommandWidth  = 3,
    parameter int PageWords     = 2048,
    parameter int LenWidth      = 12,
    parameter int TimeoutCycles = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CommandWidth-1:0] req_cmd,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [LenWidth-1:0]     req_len,
    input  logic                    wr_valid,
    input  logic [DIOWidth-1:0]     wr_data,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic [DIOWidth-1:0]     rd_data,
    input  logic                    rd_ready,
    output logic                    resp_valid,
    output logic [1:0]              resp_code,
    output logic [DIOWidth-1:0]     buf_in,
    output logic                    buf_sel,
    output logic                    buf_we,
    output logic                    buf_re,
    input  logic [DIOWidth-1:0]     buf_out,
    output logic [CommandWidth-1:0] nfc_cmd,
    output logic [AddressWidth-1:0] RWA,
    output logic                    nfc_start,
    input  logic                    nfc_done,
    input  logic                    command_error
);

    seq_state_t              state_q, state_d;
    logic [CommandWidth-1:0] cmd_q, cmd_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic [LenWidth-1:0]     count_q, count_d;
    logic                    req_ready_q, req_ready_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    buf_sel_q, buf_sel_d;
    logic                    nfc_start_q, nfc_start_d;
    logic [CommandWidth-1:0] nfc_cmd_q, nfc_cmd_d;
    logic [AddressWidth-1:0] rwa_q, rwa_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [1:0]              resp_code_q, resp_code_d;
    logic [1:0]              rsp_sel;

    logic                    cmd_prg, cmd_read, cmd_erase, len_bad;
    logic [LenWidth-1:0]     count_inc;
    logic                    wait_expired;
    logic                    rd_pop, rd_pend;

    assign cmd_prg   = (cmd_q == CommandWidth'(CMD_PRG));
    assign cmd_read  = (cmd_q == CommandWidth'(CMD_READ));
    assign cmd_erase = (cmd_q == CommandWidth'(CMD_ERASE));
    assign len_bad   = (len_q == '0) || (len_q > LenWidth'(PageWords));
    assign count_inc = count_q + LenWidth'(1);

    // Program data goes straight through to the buffer on each accepted word
    assign buf_we = wr_valid && wr_ready_q;
    assign buf_in = buf_we ? wr_data : '0;

`ifdef NFC_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] timer_q, timer_d;

    // Watchdog counts cycles spent in WAIT, restarting on every entry
    always_comb begin
        timer_d = (state_q == ST_WAIT) ? timer_q + TW'(1) : '0;
    end

    // Watchdog register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign wait_expired = (timer_q == TW'(TimeoutCycles - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles == 0);
    assign wait_expired   = 1'b0;
`endif

    nfc_seq_rdbuf #(
        .DIOWidth(DIOWidth)
    ) u_rdbuf (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_DRAIN),
        .more     (count_q < len_q),
        .buf_out  (buf_out),
        .rd_ready (rd_ready),
        .buf_re   (buf_re),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pop      (rd_pop),
        .pend     (rd_pend)
    );

    // Next-state logic; registered outputs are derived from the next state
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        rsp_sel = RSP_OK;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d   = req_cmd;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    count_d = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!(cmd_prg || cmd_read || cmd_erase) || (!cmd_erase && len_bad)) begin
                    rsp_sel = RSP_ILLEGAL;
                    state_d = ST_RESP;
                end else if (cmd_prg) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_FILL: begin
                if (buf_we) begin
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                count_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (nfc_done) begin
                    if (command_error) begin
                        rsp_sel = RSP_NFCERR;
                        state_d = ST_RESP;
                    end else if (cmd_read) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (wait_expired) begin
                    rsp_sel = RSP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (buf_re) begin
                    count_d = count_inc;
                end
                if ((count_q == len_q) && rd_pop && !rd_pend) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        wr_ready_d   = (state_d == ST_FILL) && (count_d < len_q);
        buf_sel_d    = (state_d == ST_FILL) || (state_d == ST_DRAIN);
        nfc_start_d  = (state_d == ST_START);
        nfc_cmd_d    = ((state_d == ST_START) || (state_d == ST_WAIT)) ? cmd_d : '0;
        rwa_d        = ((state_d == ST_START) || (state_d == ST_WAIT)) ? addr_d : '0;
        resp_valid_d = (state_d == ST_RESP);
        resp_code_d  = (state_d == ST_RESP) ? rsp_sel : RSP_OK;
    end

    // Sequencer state, latched request and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            req_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            buf_sel_q    <= 1'b0;
            nfc_start_q  <= 1'b0;
            nfc_cmd_q    <= '0;
            rwa_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RSP_OK;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            count_q      <= count_d;
            req_ready_q  <= req_ready_d;
            wr_ready_q   <= wr_ready_d;
            buf_sel_q    <= buf_sel_d;
            nfc_start_q  <= nfc_start_d;
            nfc_cmd_q    <= nfc_cmd_d;
            rwa_q        <= rwa_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wr_ready   = wr_ready_q;
    assign buf_sel    = buf_sel_q;
    assign nfc_start  = nfc_start_q;
    assign nfc_cmd    = nfc_cmd_q;
    assign RWA        = rwa_q;
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;

endmodule

// File: tb/tb_nfc_host_seq.sv
// Scoreboard bench for nfc_host_seq: stimulus pushes expected buffer writes,
// NFC starts, read words and completion codes; a negedge monitor pops and
// compares whenever the DUT presents the matching event.
module tb_nfc_host_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_cmd;
    logic [15:0] req_addr;
    logic [11:0] req_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [15:0] buf_in, buf_out;
    logic        buf_sel, buf_we, buf_re;
    logic [2:0]  nfc_cmd;
    logic [15:0] RWA;
    logic        nfc_start, nfc_done, command_error;

    nfc_host_seq #(
        .DIOWidth(16), .AddressWidth(16), .CommandWidth(3),
        .PageWords(2048), .LenWidth(12), .TimeoutCycles(20)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .buf_in(buf_in), .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re),
        .buf_out(buf_out), .nfc_cmd(nfc_cmd), .RWA(RWA), .nfc_start(nfc_start),
        .nfc_done(nfc_done), .command_error(command_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_we = 0, cnt_re = 0, cnt_rd = 0, cnt_start = 0, cnt_resp = 0;

    logic [15:0] q_we[$];
    logic [15:0] q_rd[$];
    logic [18:0] q_start[$];
    logic [1:0]  q_resp[$];

    logic        nfc_auto = 1'b1;
    logic        nfc_err  = 1'b0;
    logic [15:0] mem [0:7];
    logic [15:0] wvec [0:3];
    logic [2:0]  rptr = '0;
    logic        sel_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur as expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (buf_we) begin
                cnt_we++;
                if (q_we.size() == 0) note_fail("unexpected_buf_we");
                else chk("buf_in", 64'(buf_in), 64'(q_we.pop_front()));
            end
            if (buf_re) cnt_re++;
            if (nfc_start) begin
                cnt_start++;
                if (q_start.size() == 0) note_fail("unexpected_nfc_start");
                else chk("nfc_cmd_rwa", 64'({nfc_cmd, RWA}), 64'(q_start.pop_front()));
            end
            if (rd_valid && rd_ready) begin
                cnt_rd++;
                if (q_rd.size() == 0) note_fail("unexpected_rd_data");
                else chk("rd_data", 64'(rd_data), 64'(q_rd.pop_front()));
            end
            if (resp_valid) begin
                cnt_resp++;
                if (q_resp.size() == 0) note_fail("unexpected_resp");
                else chk("resp_code", 64'(resp_code), 64'(q_resp.pop_front()));
            end
        end
    end

    // Page buffer model: pointer restarts on buf_sel rising, data a cycle after buf_re
    always @(posedge clk) begin
        logic [2:0] idx;
        idx = (buf_sel && !sel_prev) ? 3'd0 : rptr;
        sel_prev <= buf_sel;
        if (buf_re) begin
            buf_out <= mem[idx];
            rptr    <= idx + 3'd1;
        end else if (buf_sel && !sel_prev) begin
            rptr <= 3'd0;
        end
    end

    // NFC model: answers each start with a done pulse three cycles later
    initial begin
        nfc_done = 1'b0;
        command_error = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && nfc_start && nfc_auto) begin
                repeat (3) @(posedge clk);
                #1;
                nfc_done = 1'b1;
                command_error = nfc_err;
                @(posedge clk);
                #1;
                nfc_done = 1'b0;
                command_error = 1'b0;
            end
        end
    end

    // Host read side toggles rd_ready every cycle
    initial begin
        rd_ready = 1'b0;
        forever begin
            step();
            rd_ready = ~rd_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic request(input logic [2:0] c, input logic [15:0] a, input logic [11:0] l);
        int g = 0;
        req_valid = 1'b1;
        req_cmd = c;
        req_addr = a;
        req_len = l;
        while (!req_ready && g < 50) begin step(); g++; end
        if (!req_ready) note_fail("req_ready_wait");
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int gap_at);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            if (i == gap_at) begin
                wr_valid = 1'b0;
                step();
                step();
            end
            wr_valid = 1'b1;
            wr_data = wvec[i];
            while (!wr_ready && g < 50) begin step(); g++; end
            if (!wr_ready) note_fail("wr_ready_wait");
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget, output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < budget) begin step(); cyc++; end
        if (!resp_valid) note_fail("resp_wait");
        step();
    endtask

    initial begin
        int cyc;
        int b_we, b_re, b_rd, b_st;
        reset = 1'b0;
        req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        mem[0] = 16'h00B1; mem[1] = 16'h00B2; mem[2] = 16'h00B3; mem[3] = 16'h00B4;
        mem[4] = 16'h0; mem[5] = 16'h0; mem[6] = 16'h0; mem[7] = 16'h0;
        repeat (3) step();

        // Reset state
        chk("reset_outputs", 64'({req_ready, wr_ready, rd_valid, rd_data, resp_valid, resp_code,
                                  buf_in, buf_sel, buf_we, buf_re, nfc_cmd, RWA, nfc_start}), 64'd0);
        reset = 1'b1;
        step();
        step();
        chk("req_ready_after_reset", 64'(req_ready), 64'd1);

        // Program 4 words with a wr_valid gap
        b_we = cnt_we; b_st = cnt_start;
        wvec[0] = 16'h00A1; wvec[1] = 16'h00A2; wvec[2] = 16'h00A3; wvec[3] = 16'h00A4;
        for (int i = 0; i < 4; i++) q_we.push_back(wvec[i]);
        q_start.push_back({3'b001, 16'h0040});
        q_resp.push_back(2'b00);
        request(3'b001, 16'h0040, 12'd4);
        send_words(4, 2);
        wait_resp(100, cyc);
        chk("prg_we_count", 64'(cnt_we - b_we), 64'd4);
        chk("prg_start_count", 64'(cnt_start - b_st), 64'd1);

        // Read 3 words with rd_ready toggling
        b_re = cnt_re; b_rd = cnt_rd; b_we = cnt_we;
        q_start.push_back({3'b010, 16'h0100});
        q_rd.push_back(16'h00B1); q_rd.push_back(16'h00B2); q_rd.push_back(16'h00B3);
        q_resp.push_back(2'b00);
        request(3'b010, 16'h0100, 12'd3);
        wait_resp(200, cyc);
        chk("read_re_count", 64'(cnt_re - b_re), 64'd3);
        chk("read_rd_count", 64'(cnt_rd - b_rd), 64'd3);
        chk("read_we_count", 64'(cnt_we - b_we), 64'd0);

        // Erase and read completing with an NFC error
        nfc_err = 1'b1;
        b_re = cnt_re; b_we = cnt_we;
        q_start.push_back({3'b100, 16'h0300});
        q_resp.push_back(2'b01);
        request(3'b100, 16'h0300, 12'd0);
        wait_resp(100, cyc);
        q_start.push_back({3'b010, 16'h0400});
        q_resp.push_back(2'b01);
        request(3'b010, 16'h0400, 12'd2);
        wait_resp(100, cyc);
        chk("err_we_count", 64'(cnt_we - b_we), 64'd0);
        chk("err_re_count", 64'(cnt_re - b_re), 64'd0);
        nfc_err = 1'b0;

        // Illegal requests: len 0, len 2049, unknown command
        b_st = cnt_start;
        for (int k = 0; k < 3; k++) begin
            logic [2:0]  c;
            logic [11:0] l;
            c = (k == 2) ? 3'b111 : 3'b010;
            l = (k == 0) ? 12'd0 : ((k == 1) ? 12'd2049 : 12'd1);
            q_resp.push_back(2'b10);
            request(c, 16'h0010, l);
            wait_resp(10, cyc);
            chk("illegal_latency", 64'(cyc), 64'd1);
        end
        chk("illegal_start_count", 64'(cnt_start - b_st), 64'd0);

        // Reset during FILL after 2 of 4 words
        b_st = cnt_start;
        wvec[0] = 16'h00D1; wvec[1] = 16'h00D2;
        q_we.push_back(16'h00D1); q_we.push_back(16'h00D2);
        request(3'b001, 16'h0500, 12'd4);
        send_words(2, 9);
        reset = 1'b0;
        #1;
        chk("reset_midfill_outputs", 64'({req_ready, wr_ready, rd_valid, rd_data, resp_valid, resp_code,
                                          buf_in, buf_sel, buf_we, buf_re, nfc_cmd, RWA, nfc_start}), 64'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        chk("midfill_we_left", 64'(q_we.size()), 64'd0);
        chk("midfill_no_start", 64'(cnt_start - b_st), 64'd0);

        // Fresh program after reset
        b_we = cnt_we;
        wvec[0] = 16'h00C1; wvec[1] = 16'h00C2; wvec[2] = 16'h00C3; wvec[3] = 16'h00C4;
        for (int i = 0; i < 4; i++) q_we.push_back(wvec[i]);
        q_start.push_back({3'b001, 16'h0600});
        q_resp.push_back(2'b00);
        request(3'b001, 16'h0600, 12'd4);
        send_words(4, 9);
        wait_resp(100, cyc);
        chk("post_reset_we_count", 64'(cnt_we - b_we), 64'd4);

`ifdef NFC_TIMEOUT_EN
        // Watchdog: no nfc_done, code 11 after 20 WAIT cycles, late done ignored
        begin
            int g = 0;
            int b_resp;
            nfc_auto = 1'b0;
            q_start.push_back({3'b100, 16'h0700});
            q_resp.push_back(2'b11);
            request(3'b100, 16'h0700, 12'd0);
            while (!nfc_start && g < 10) begin step(); g++; end
            if (!nfc_start) note_fail("timeout_start_wait");
            wait_resp(40, cyc);
            chk("timeout_latency", 64'(cyc), 64'd21);
            b_resp = cnt_resp;
            nfc_done = 1'b1;
            step();
            nfc_done = 1'b0;
            repeat (3) step();
            chk("late_done_ignored", 64'(cnt_resp - b_resp), 64'd0);
            nfc_auto = 1'b1;
        end
`endif

        repeat (4) step();
        chk("sb_we_empty", 64'(q_we.size()), 64'd0);
        chk("sb_start_empty", 64'(q_start.size()), 64'd0);
        chk("sb_rd_empty", 64'(q_rd.size()), 64'd0);
        chk("sb_resp_empty", 64'(q_resp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
